// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, PC step and the PC sequencer state encoding.
//   word_t         32-bit machine word
//   PC_STEP        sequential fetch increment in bytes
//   pcseq_state_t  RUN / PEND / HALTED states of pc_sequencer
//   align_word()   clears the two byte-offset bits of an address
package cpu_types_pkg;

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned PC_STEP = 4;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PEND   = 2'd1,
        HALTED = 2'd2
    } pcseq_state_t;

    // Word-align an address by clearing its byte offset.
    function automatic word_t align_word(input word_t addr);
        return {addr[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect selector, oldest instruction first:
// EX branch > ID jump-register > ID jump.
//   br_redir/br_target  EX-stage branch redirect
//   jr_redir/jr_target  ID-stage JR redirect
//   j_redir/j_target    ID-stage J/JAL redirect
//   valid               some redirect source is active
//   target              target of the winning source (0 when none)
//   is_branch           winner is the EX-stage branch
module pc_redirect_arb
    import cpu_types_pkg::*;
(
    input  logic  br_redir,
    input  word_t br_target,
    input  logic  jr_redir,
    input  word_t jr_target,
    input  logic  j_redir,
    input  word_t j_target,
    output logic  valid,
    output word_t target,
    output logic  is_branch
);

    // Priority select; defaults describe the no-redirect case.
    always_comb begin
        valid     = 1'b0;
        target    = '0;
        is_branch = 1'b0;
        if (br_redir) begin
            valid     = 1'b1;
            target    = br_target;
            is_branch = 1'b1;
        end else if (jr_redir) begin
            valid  = 1'b1;
            target = jr_target;
        end else if (j_redir) begin
            valid  = 1'b1;
            target = j_target;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: chooses each cycle whether the PC advances and
// to what, arbitrating redirects against sequential fetch, holding a redirect
// across an icache miss, and owning halt.
//   CLK, nRST            clock, synchronous active-low reset
//   curr_pc, ihit, stall current PC, icache hit, hazard hold
//   halt                 HALT retired
//   br/jr/j_redir+target redirect requests (priority br > jr > j)
//   pc_en, new_pc        PC load enable and value
//   flush_ifid/idex      pipeline squash pulses
//   redir_pend, halted   state indicators
//   redir_cnt            saturating count of accepted redirects
//   misalign             misaligned-target trap pulse
// Build option: define PC_SEQ_ALIGN_TRAP_EN to replace a misaligned redirect
// target with TRAP_VECTOR; otherwise targets are forced word-aligned.
module pc_sequencer
    import cpu_types_pkg::*;
#(
    parameter word_t       PC_INIT     = 32'h0000_0000,
    parameter word_t       TRAP_VECTOR = 32'h0000_0FF0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  word_t            curr_pc,
    input  logic             ihit,
    input  logic             stall,
    input  logic             halt,
    input  logic             br_redir,
    input  word_t            br_target,
    input  logic             jr_redir,
    input  word_t            jr_target,
    input  logic             j_redir,
    input  word_t            j_target,
    output logic             pc_en,
    output word_t            new_pc,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             redir_pend,
    output logic             halted,
    output logic [CNT_W-1:0] redir_cnt,
    output logic             misalign
);

    pcseq_state_t     state_q, state_d;
    word_t            pend_tgt_q, pend_tgt_d;
    logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;

    logic  arb_valid;
    word_t arb_target;
    logic  arb_is_branch;

    word_t fixed_tgt_c;
    logic  misaligned_c;
    logic  accept_c;

    pc_redirect_arb u_arb (
        .br_redir  (br_redir),
        .br_target (br_target),
        .jr_redir  (jr_redir),
        .jr_target (jr_target),
        .j_redir   (j_redir),
        .j_target  (j_target),
        .valid     (arb_valid),
        .target    (arb_target),
        .is_branch (arb_is_branch)
    );

    // The restart PC lives in program_counter; kept here only so both agree.
    logic unused_pc_init;
    assign unused_pc_init = ^PC_INIT;

    // Target legalisation for the winning redirect.
`ifdef PC_SEQ_ALIGN_TRAP_EN
    always_comb begin
        misaligned_c = (arb_target[1:0] != 2'b00);
        fixed_tgt_c  = misaligned_c ? TRAP_VECTOR : arb_target;
    end
`else
    logic unused_align;
    assign unused_align = ^{TRAP_VECTOR, arb_target[1:0]};

    always_comb begin
        misaligned_c = 1'b0;
        fixed_tgt_c  = align_word(arb_target);
    end
`endif

    // A redirect is taken only in RUN, and halt beats any redirect.
    assign accept_c = (state_q == RUN) && !halt && arb_valid;

    // State register.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q     <= RUN;
            pend_tgt_q  <= '0;
            redir_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_tgt_q  <= pend_tgt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    // Next-state, pending target and counter update.
    always_comb begin
        state_d     = state_q;
        pend_tgt_d  = pend_tgt_q;
        redir_cnt_d = redir_cnt_q;

        if (accept_c && (redir_cnt_q != {CNT_W{1'b1}})) begin
            redir_cnt_d = redir_cnt_q + CNT_W'(1);
        end

        if (halt) begin
            state_d = HALTED;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (arb_valid && !ihit) begin
                        state_d    = PEND;
                        pend_tgt_d = fixed_tgt_c;
                    end
                end
                PEND: begin
                    if (ihit) begin
                        state_d = RUN;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    // Outputs: combinational from state and inputs, all forced low in reset.
    always_comb begin
        pc_en      = 1'b0;
        new_pc     = '0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        redir_pend = 1'b0;
        halted     = 1'b0;
        misalign   = 1'b0;
        redir_cnt  = '0;

        if (nRST) begin
            redir_cnt = redir_cnt_q;
            unique case (state_q)
                RUN: begin
                    if (!halt) begin
                        if (arb_valid) begin
                            pc_en      = ihit;
                            new_pc     = fixed_tgt_c;
                            flush_ifid = 1'b1;
                            flush_idex = arb_is_branch;
                            misalign   = misaligned_c;
                        end else begin
                            pc_en  = ihit && !stall;
                            new_pc = curr_pc + WORD_W'(PC_STEP);
                        end
                    end
                end
                PEND: begin
                    redir_pend = 1'b1;
                    new_pc     = pend_tgt_q;
                    pc_en      = ihit && !halt;
                end
                HALTED: begin
                    halted = 1'b1;
                end
                default: begin
                    pc_en = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (default CNT_W=16).
// Expectations for the misaligned-target case follow PC_SEQ_ALIGN_TRAP_EN.
module tb_pc_sequencer;
    import cpu_types_pkg::*;

    localparam int unsigned CNT_W = 16;

    logic             CLK = 1'b0;
    logic             nRST;
    word_t            curr_pc;
    logic             ihit, stall, halt;
    logic             br_redir, jr_redir, j_redir;
    word_t            br_target, jr_target, j_target;
    logic             pc_en, flush_ifid, flush_idex, redir_pend, halted, misalign;
    word_t            new_pc;
    logic [CNT_W-1:0] redir_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(
        .PC_INIT     (32'h0000_0000),
        .TRAP_VECTOR (32'h0000_0FF0),
        .CNT_W       (CNT_W)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .curr_pc    (curr_pc),
        .ihit       (ihit),
        .stall      (stall),
        .halt       (halt),
        .br_redir   (br_redir),
        .br_target  (br_target),
        .jr_redir   (jr_redir),
        .jr_target  (jr_target),
        .j_redir    (j_redir),
        .j_target   (j_target),
        .pc_en      (pc_en),
        .new_pc     (new_pc),
        .flush_ifid (flush_ifid),
        .flush_idex (flush_idex),
        .redir_pend (redir_pend),
        .halted     (halted),
        .redir_cnt  (redir_cnt),
        .misalign   (misalign)
    );

    always #5 CLK = ~CLK;

    task automatic clear_inputs();
        ihit      = 1'b0;
        stall     = 1'b0;
        halt      = 1'b0;
        br_redir  = 1'b0;
        jr_redir  = 1'b0;
        j_redir   = 1'b0;
        br_target = 32'h0;
        jr_target = 32'h0;
        j_target  = 32'h0;
    endtask

    // Advance one edge, then settle away from it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        nRST     = 1'b0;
        curr_pc  = 32'h100;
        ihit     = 1'b1;
        br_redir = 1'b1;
        br_target = 32'h200;
        #1;
        n_checks++;
        if (pc_en !== 1'b0 || flush_ifid !== 1'b0 || flush_idex !== 1'b0 || new_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outs: pc_en=%0b flush_ifid=%0b flush_idex=%0b new_pc=%h, want all 0",
                     pc_en, flush_ifid, flush_idex, new_pc);
        end
        tick();
        clear_inputs();
        nRST = 1'b1;
        #1;
        n_checks++;
        if (redir_cnt !== 16'h0 || halted !== 1'b0 || redir_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: cnt=%h halted=%0b pend=%0b, want 0/0/0", redir_cnt, halted, redir_pend);
        end
    endtask

    task automatic test_sequential();
        clear_inputs();
        curr_pc = 32'h100;
        ihit    = 1'b1;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || new_pc !== 32'h104 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_advance: pc_en=%0b new_pc=%h fl=%0b%0b, want 1 00000104 00",
                     pc_en, new_pc, flush_ifid, flush_idex);
        end
        stall = 1'b1;
        #1;
        n_checks++;
        if (pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_stall: pc_en=%0b want 0", pc_en);
        end
        stall = 1'b0;
        ihit  = 1'b0;
        #1;
        n_checks++;
        if (pc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL seq_miss: pc_en=%0b want 0", pc_en);
        end
        ihit    = 1'b1;
        curr_pc = 32'hFFFF_FFFC;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || new_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL seq_wrap: pc_en=%0b new_pc=%h want 1 00000000", pc_en, new_pc);
        end
        tick();
    endtask

    task automatic test_priority();
        clear_inputs();
        curr_pc   = 32'h100;
        ihit      = 1'b1;
        br_redir  = 1'b1;
        br_target = 32'h200;
        j_redir   = 1'b1;
        j_target  = 32'h300;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || new_pc !== 32'h200 || flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_br: pc_en=%0b new_pc=%h fl=%0b%0b want 1 00000200 11",
                     pc_en, new_pc, flush_ifid, flush_idex);
        end
        tick();
        n_checks++;
        if (redir_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL prio_cnt1: cnt=%0d want 1", redir_cnt);
        end
        br_redir  = 1'b0;
        jr_redir  = 1'b1;
        jr_target = 32'h440;
        #1;
        n_checks++;
        if (new_pc !== 32'h440 || flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_jr: new_pc=%h fl=%0b%0b want 00000440 10", new_pc, flush_ifid, flush_idex);
        end
        tick();
        jr_redir = 1'b0;
        stall    = 1'b1;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || new_pc !== 32'h300) begin
            n_fail++;
            $display("FAIL prio_j_stall: pc_en=%0b new_pc=%h want 1 00000300", pc_en, new_pc);
        end
        tick();
        n_checks++;
        if (redir_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL prio_cnt3: cnt=%0d want 3", redir_cnt);
        end
    endtask

    task automatic test_pend();
        clear_inputs();
        curr_pc   = 32'h300;
        jr_redir  = 1'b1;
        jr_target = 32'h480;
        #1;
        n_checks++;
        if (pc_en !== 1'b0 || flush_ifid !== 1'b1 || redir_pend !== 1'b0) begin
            n_fail++;
            $display("FAIL pend_accept: pc_en=%0b flush_ifid=%0b pend=%0b want 0 1 0",
                     pc_en, flush_ifid, redir_pend);
        end
        tick();
        jr_redir = 1'b0;
        j_redir  = 1'b1;
        j_target = 32'h900;
        stall    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_checks++;
            if (pc_en !== 1'b0 || redir_pend !== 1'b1 || flush_ifid !== 1'b0 || redir_cnt !== 16'd4) begin
                n_fail++;
                $display("FAIL pend_hold%0d: pc_en=%0b pend=%0b flush=%0b cnt=%0d want 0 1 0 4",
                         i, pc_en, redir_pend, flush_ifid, redir_cnt);
            end
            tick();
        end
        j_redir = 1'b0;
        ihit    = 1'b1;
        #1;
        n_checks++;
        if (pc_en !== 1'b1 || new_pc !== 32'h480 || redir_pend !== 1'b1) begin
            n_fail++;
            $display("FAIL pend_release: pc_en=%0b new_pc=%h pend=%0b want 1 00000480 1",
                     pc_en, new_pc, redir_pend);
        end
        tick();
        stall = 1'b0;
        #1;
        n_checks++;
        if (redir_pend !== 1'b0 || redir_cnt !== 16'd4) begin
            n_fail++;
            $display("FAIL pend_back_run: pend=%0b cnt=%0d want 0 4", redir_pend, redir_cnt);
        end
    endtask

    task automatic test_misalign();
        word_t exp_pc;
        logic  exp_mis;
`ifdef PC_SEQ_ALIGN_TRAP_EN
        exp_pc  = 32'h0000_0FF0;
        exp_mis = 1'b1;
`else
        exp_pc  = 32'h0000_0300;
        exp_mis = 1'b0;
`endif
        clear_inputs();
        ihit     = 1'b1;
        j_redir  = 1'b1;
        j_target = 32'h302;
        #1;
        n_checks++;
        if (new_pc !== exp_pc || misalign !== exp_mis || pc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL misalign_tgt: new_pc=%h misalign=%0b pc_en=%0b want %h %0b 1",
                     new_pc, misalign, pc_en, exp_pc, exp_mis);
        end
        tick();
        j_redir = 1'b0;
        #1;
        n_checks++;
        if (redir_cnt !== 16'd5 || misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL misalign_cnt: cnt=%0d misalign=%0b want 5 0", redir_cnt, misalign);
        end
    endtask

    task automatic test_halt();
        clear_inputs();
        ihit      = 1'b1;
        halt      = 1'b1;
        br_redir  = 1'b1;
        br_target = 32'h600;
        #1;
        n_checks++;
        if (pc_en !== 1'b0 || flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_beats_br: pc_en=%0b fl=%0b%0b want 0 00", pc_en, flush_ifid, flush_idex);
        end
        tick();
        clear_inputs();
        ihit = 1'b1;
        j_redir  = 1'b1;
        j_target = 32'h700;
        #1;
        n_checks++;
        if (halted !== 1'b1 || redir_cnt !== 16'd5) begin
            n_fail++;
            $display("FAIL halt_enter: halted=%0b cnt=%0d want 1 5", halted, redir_cnt);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            n_checks++;
            if (halted !== 1'b1 || pc_en !== 1'b0 || flush_ifid !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold%0d: halted=%0b pc_en=%0b flush=%0b want 1 0 0",
                         i, halted, pc_en, flush_ifid);
            end
        end
        clear_inputs();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        ihit = 1'b1;
        curr_pc = 32'h20;
        #1;
        n_checks++;
        if (halted !== 1'b0 || redir_cnt !== 16'd0 || pc_en !== 1'b1 || new_pc !== 32'h24) begin
            n_fail++;
            $display("FAIL halt_reset: halted=%0b cnt=%0d pc_en=%0b new_pc=%h want 0 0 1 00000024",
                     halted, redir_cnt, pc_en, new_pc);
        end
    endtask

    task automatic test_pend_reset();
        clear_inputs();
        curr_pc   = 32'h40;
        br_redir  = 1'b1;
        br_target = 32'h800;
        tick();
        clear_inputs();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
        ihit = 1'b1;
        #1;
        n_checks++;
        if (redir_pend !== 1'b0 || pc_en !== 1'b1 || new_pc !== 32'h44 || redir_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL pend_reset: pend=%0b pc_en=%0b new_pc=%h cnt=%0d want 0 1 00000044 0",
                     redir_pend, pc_en, new_pc, redir_cnt);
        end
        tick();
    endtask

    task automatic test_saturation();
        clear_inputs();
        ihit     = 1'b1;
        j_redir  = 1'b1;
        j_target = 32'h1000;
        for (int i = 0; i < 65534; i++) begin
            tick();
        end
        n_checks++;
        if (redir_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_near: cnt=%h want fffe", redir_cnt);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        n_checks++;
        if (redir_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: cnt=%h want ffff", redir_cnt);
        end
        clear_inputs();
    endtask

    initial begin
        curr_pc = 32'h0;
        nRST    = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_priority();
        test_pend();
        test_misalign();
        test_halt();
        test_pend_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
